// File: rtl/sdram_ctrl.sv
// Line-burst SDRAM model and controller for the cache refill/write-back path.
// One request moves a 32-byte line: access latency, 32 beats, then a done pulse.
module sdram_ctrl #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int OFFSET_WIDTH = 5,
   parameter int ACCESS_LAT   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   Address_sdram,
   input  logic                    wr_rd_sdram,
   input  logic                    mstrb_sdram,
   input  logic [DATA_WIDTH-1:0]   Din_sdram,
   output logic [DATA_WIDTH-1:0]   Dout_sdram,
   output logic [OFFSET_WIDTH-1:0] offset_sdram,
   output logic                    beat_sdram,
   output logic                    busy_sdram,
   output logic                    done_sdram
);

   localparam int LINE_W = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT_LAST = 4'(ACCESS_LAT - 1);
   localparam logic [OFFSET_WIDTH-1:0] BEAT_LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      LAT,
      XFER,
      DONE
   } state_t;

   state_t                  state;
   logic [LINE_W-1:0]       line;
   logic                    wr;
   logic [3:0]              lat_cnt;
   logic [OFFSET_WIDTH-1:0] off_inc;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    unused_low_addr;

   // Cells hold data XOR the address pattern, so zero power-up content
   // reads back as the pattern and no reset sweep is needed.
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [15:0] a16;
      a16 = 16'(a);
      return DATA_WIDTH'(a16[7:0] ^ a16[15:8]);
   endfunction

   assign unused_low_addr = ^Address_sdram[OFFSET_WIDTH-1:0];
   assign off_inc  = offset_sdram + OFFSET_WIDTH'(1);
   assign cur_addr = {line, offset_sdram};
   assign rd_addr  = (state == LAT) ? {line, {OFFSET_WIDTH{1'b0}}}
                                    : {line, off_inc};
   assign rd_data  = mem[rd_addr] ^ pattern(rd_addr);

   always_ff @(posedge clk) begin
      if (state == XFER && wr)
         mem[cur_addr] <= Din_sdram ^ pattern(cur_addr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         line         <= '0;
         wr           <= 1'b0;
         lat_cnt      <= '0;
         offset_sdram <= '0;
         Dout_sdram   <= '0;
         beat_sdram   <= 1'b0;
         busy_sdram   <= 1'b0;
         done_sdram   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mstrb_sdram) begin
                  line         <= Address_sdram[ADDR_WIDTH-1:OFFSET_WIDTH];
                  wr           <= wr_rd_sdram;
                  lat_cnt      <= '0;
                  offset_sdram <= '0;
                  busy_sdram   <= 1'b1;
                  state        <= LAT;
               end
            end
            LAT: begin
               if (lat_cnt == LAT_LAST) begin
                  beat_sdram <= 1'b1;
                  Dout_sdram <= wr ? '0 : rd_data;
                  state      <= XFER;
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            XFER: begin
               if (offset_sdram == BEAT_LAST) begin
                  beat_sdram   <= 1'b0;
                  busy_sdram   <= 1'b0;
                  done_sdram   <= 1'b1;
                  offset_sdram <= '0;
                  Dout_sdram   <= '0;
                  state        <= DONE;
               end else begin
                  offset_sdram <= off_inc;
                  Dout_sdram   <= wr ? '0 : rd_data;
               end
            end
            DONE: begin
               done_sdram <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: table vectors, hand sequences and random line
// transfers checked cycle by cycle against a byte-array model.
module tb_sdram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address;
   logic        wr_rd, mstrb0, mstrb1, din_fixed;
   logic [7:0]  din_key, din0, din1, dout0, dout1;
   logic [4:0]  off0, off1;
   logic        beat0, beat1, busy0, busy1, done0, done1;

   int passed = 0;
   int total  = 0;

   logic [7:0] model [2][65536];
   logic [7:0] obs_line [32];

   typedef struct {
      int          sel;
      logic [15:0] addr;
      logic        wr;
      logic        fixed;
      logic [7:0]  key;
      logic [7:0]  exp_first;
      int          exp_done;
   } vec_t;

   always #5 clk = ~clk;

   assign din0 = din_fixed ? din_key : 8'(off0) + din_key;
   assign din1 = din_fixed ? din_key : 8'(off1) + din_key;

   sdram_ctrl #(.ACCESS_LAT(4)) dut0 (
      .clk(clk), .rst(rst), .Address_sdram(address),
      .wr_rd_sdram(wr_rd), .mstrb_sdram(mstrb0), .Din_sdram(din0),
      .Dout_sdram(dout0), .offset_sdram(off0), .beat_sdram(beat0),
      .busy_sdram(busy0), .done_sdram(done0)
   );

   sdram_ctrl #(.ACCESS_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .Address_sdram(address),
      .wr_rd_sdram(wr_rd), .mstrb_sdram(mstrb1), .Din_sdram(din1),
      .Dout_sdram(dout1), .offset_sdram(off1), .beat_sdram(beat1),
      .busy_sdram(busy1), .done_sdram(done1)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // {busy, beat, done, offset[4:0], dout[7:0]}
   function automatic logic [15:0] act_vec(input int sel);
      if (sel != 0) return {busy1, beat1, done1, off1, dout1};
      return {busy0, beat0, done0, off0, dout0};
   endfunction

   // Cycle k counts from the cycle the strobe is presented (k = 0).
   function automatic logic [15:0] exp_vec(input int sel, input int k,
                                           input logic [15:0] base,
                                           input logic wr);
      int lat;
      logic eb, ebeat, ed;
      logic [4:0] eo;
      logic [7:0] dd;
      lat   = (sel != 0) ? 1 : 4;
      eb    = (k >= 1) && (k <= lat + 32);
      ebeat = (k >= lat + 1) && (k <= lat + 32);
      ed    = (k == lat + 33);
      eo    = ebeat ? 5'(k - lat - 1) : 5'd0;
      dd    = (ebeat && !wr) ? model[sel][int'(base) + int'(eo)] : 8'h00;
      return {eb, ebeat, ed, eo, dd};
   endfunction

   task automatic check_cycle(input string tag, input int sel, input int k,
                              input logic [15:0] base, input logic wr);
      logic [15:0] a, e;
      a = act_vec(sel);
      e = exp_vec(sel, k, base, wr);
      if (wr) a[7:0] = 8'h00;
      if (a[14] && !wr) obs_line[a[12:8]] = a[7:0];
      check($sformatf("%s_c%0d", tag, k), 32'(a), 32'(e));
   endtask

   // Caller is at a falling edge; the strobe is sampled at the next rise.
   task automatic run_txn(input int sel, input logic [15:0] addr,
                          input logic wr, input logic fixed,
                          input logic [7:0] key, input int poke,
                          input int extra, output int done_k,
                          output logic [7:0] first_dout);
      int lat;
      bit seen;
      logic [15:0] base, v;
      lat  = (sel != 0) ? 1 : 4;
      base = addr & 16'hFFE0;
      done_k = -1;
      first_dout = 8'h00;
      seen = 0;
      for (int i = 0; i < 32; i++) obs_line[i] = 8'h00;
      address = addr;
      wr_rd = wr;
      din_fixed = fixed;
      din_key = key;
      if (sel != 0) mstrb1 = 1'b1;
      else mstrb0 = 1'b1;
      for (int k = 1; k <= lat + 34 + extra; k++) begin
         @(negedge clk);
         v = act_vec(sel);
         check_cycle($sformatf("txn%0h", addr), sel, k, base, wr);
         if (v[13] && done_k < 0) done_k = k;
         if (v[14] && !seen) begin
            seen = 1;
            first_dout = v[7:0];
         end
         mstrb0 = 1'b0;
         mstrb1 = 1'b0;
         if (k == poke) begin
            address = 16'h0040 ^ addr;
            wr_rd = ~wr;
            if (sel != 0) mstrb1 = 1'b1;
            else mstrb0 = 1'b1;
         end
      end
      if (wr)
         for (int o = 0; o < 32; o++)
            model[sel][int'(base) + o] = fixed ? key : 8'(o) + key;
   endtask

   initial begin
      vec_t vecs[6];
      int dk;
      logic [7:0] fd;

      rst = 1'b0;
      address = '0;
      wr_rd = 1'b0;
      mstrb0 = 1'b0;
      mstrb1 = 1'b0;
      din_fixed = 1'b0;
      din_key = '0;
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 65536; a++)
            model[s][a] = 8'(a) ^ 8'(a >> 8);

      vecs[0] = '{0, 16'h1234, 1'b0, 1'b0, 8'h00, 8'h32, 37};
      vecs[1] = '{0, 16'hA5E0, 1'b1, 1'b0, 8'h80, 8'h00, 37};
      vecs[2] = '{0, 16'hA5E0, 1'b0, 1'b0, 8'h00, 8'h80, 37};
      vecs[3] = '{1, 16'h1234, 1'b0, 1'b0, 8'h00, 8'h32, 34};
      vecs[4] = '{0, 16'hFFE7, 1'b0, 1'b0, 8'h00, 8'h1F, 37};
      vecs[5] = '{1, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 34};

      repeat (3) @(negedge clk);
      check("reset_dut0", 32'(act_vec(0)), 32'd0);
      check("reset_dut1", 32'(act_vec(1)), 32'd0);
      rst = 1'b1;

      // Entries run back to back: each strobe lands in the first idle cycle.
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].sel, vecs[i].addr, vecs[i].wr, vecs[i].fixed,
                 vecs[i].key, 0, 0, dk, fd);
         check($sformatf("tbl%0d_done", i), 32'(dk), 32'(vecs[i].exp_done));
         if (!vecs[i].wr)
            check($sformatf("tbl%0d_first", i), 32'(fd),
                  32'(vecs[i].exp_first));
      end

      run_txn(0, 16'hA5E0, 1'b0, 1'b0, 8'h00, 0, 0, dk, fd);
      check("wb_byte31", 32'(obs_line[31]), 32'h9F);
      check("wb_byte16", 32'(obs_line[16]), 32'h90);

      run_txn(0, 16'h0020, 1'b0, 1'b0, 8'h00, 10, 5, dk, fd);
      check("ignore_xfer_done", 32'(dk), 32'd37);
      run_txn(0, 16'h0040, 1'b0, 1'b0, 8'h00, 37, 3, dk, fd);
      check("ignore_done_first", 32'(fd), 32'h40);

      address = 16'h4000;
      wr_rd = 1'b1;
      din_fixed = 1'b1;
      din_key = 8'hFF;
      mstrb0 = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         check_cycle("abort", 0, k, 16'h4000, 1'b1);
         mstrb0 = 1'b0;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("abort_outputs", 32'(act_vec(0)), 32'd0);
      for (int i = 0; i < 10; i++) model[0][16'h4000 + i] = 8'hFF;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_txn(0, 16'h4000, 1'b0, 1'b0, 8'h00, 0, 0, dk, fd);
      check("abort_byte9", 32'(obs_line[9]), 32'hFF);
      check("abort_byte10", 32'(obs_line[10]), 32'h4A);
      check("abort_done", 32'(dk), 32'd37);

      for (int n = 0; n < 40; n++) begin
         int sel, lat, poke, gap;
         logic [15:0] a;
         sel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         lat  = (sel != 0) ? 1 : 4;
         a    = 16'h6000 | 16'($urandom_range(0, 255));
         poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat + 33)) : 0;
         gap  = int'($urandom_range(0, 2));
         run_txn(sel, a, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 8'($urandom),
                 poke, gap, dk, fd);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sdram_ctrl.md
SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, CPU/SDRAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 5, line offset width; a line is 32 bytes.
REQ-004 SHALL have parameter ACCESS_LAT, default 4, row-access latency in cycles, legal range 1..15.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 Address_sdram  input  ADDR_WIDTH  line address from cache controller; bits [OFFSET_WIDTH-1:0] ignored.
REQ-008 wr_rd_sdram  input  1  1 = write-back line to SDRAM, 0 = fill line from SDRAM.
REQ-009 mstrb_sdram  input  1  request strobe, sampled only in IDLE.
REQ-010 Din_sdram  input  DATA_WIDTH  write-back byte from cache SRAM, driven combinationally from offset_sdram.
REQ-011 Dout_sdram  output  DATA_WIDTH  fill byte to cache SRAM, valid when beat_sdram=1.
REQ-012 offset_sdram  output  OFFSET_WIDTH  byte offset of current beat.
REQ-013 beat_sdram  output  1  one byte transferred this cycle.
REQ-014 busy_sdram  output  1  request accepted and not yet complete.
REQ-015 done_sdram  output  1  one-cycle pulse after final beat.

Function
REQ-016 SHALL contain a 2^ADDR_WIDTH x DATA_WIDTH array; at time zero mem[a] SHALL equal a[7:0] XOR a[15:8]; the array SHALL NOT be cleared by rst.
REQ-017 SHALL implement states IDLE, LAT, XFER, DONE.
REQ-018 IDLE: mstrb_sdram=1 at an edge SHALL latch Address_sdram[15:5] and wr_rd_sdram, clear latency and beat counters, go to LAT; busy_sdram=1 from that edge.
REQ-019 LAT: SHALL remain exactly ACCESS_LAT cycles, beat_sdram=0, then go to XFER.
REQ-020 XFER: SHALL last exactly 32 cycles, beat_sdram=1 each cycle, offset_sdram stepping 0,1,...,31 with no gaps.
REQ-021 Fill: Dout_sdram SHALL equal mem[{line,offset_sdram}] during each beat cycle (registered, no combinational path from inputs).
REQ-022 Write-back: at the edge ending each beat cycle, mem[{line,offset_sdram}] SHALL be written with Din_sdram.
REQ-023 Beat counter SHALL be OFFSET_WIDTH bits; at offset 31 the transfer SHALL go to DONE, never wrapping into a 33rd beat.
REQ-024 DONE: done_sdram=1, busy_sdram=0, beat_sdram=0 for exactly one cycle, then IDLE.
REQ-025 mstrb_sdram in LAT, XFER or DONE SHALL be ignored (not queued); Address_sdram/wr_rd_sdram changes after acceptance SHALL have no effect.
REQ-026 Strobe-edge to first beat SHALL be ACCESS_LAT+1 cycles; request to done_sdram pulse SHALL be ACCESS_LAT+33 cycles.
REQ-027 Outside XFER, offset_sdram SHALL hold 0 and Dout_sdram SHALL hold 0.
REQ-028 Back-to-back: a strobe at the edge after DONE (first IDLE cycle) SHALL be accepted.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, busy_sdram=0, done_sdram=0, beat_sdram=0, offset_sdram=0, Dout_sdram=0, counters 0.
REQ-030 Reset mid-XFER SHALL abort: bytes already written persist, remaining bytes unchanged, no done_sdram pulse.
REQ-031 First strobe SHALL be accepted on the first rising edge with rst=1 at and before it.

Verification
REQ-032 Fill: strobe, Address_sdram=16'h1234, wr_rd=0 -> line base 16'h1220, 4 LAT cycles, 32 beats Dout = 8'h20^8'h12 ... 8'h3F^8'h12 (first 8'h32), done pulse at cycle 37.
REQ-033 Write-back: strobe, Address 16'hA5E0, wr_rd=1, Din=offset+8'h80 -> then fill of 16'hA5E0 returns 8'h80..8'h9F.
REQ-034 Strobe ignored: second strobe with 16'h0040 during XFER of 16'h0020 -> exactly 32 beats, single done, no second busy period.
REQ-035 Reset abort: rst=0 after beat offset 9 of write-back 16'h4000, Din=8'hFF -> bytes 16'h4000..4009 = FF, 16'h400A = 8'h4A, all outputs 0 immediately.
REQ-036 Back-to-back: strobe in first IDLE cycle after done -> busy re-asserts next cycle, second done 37 cycles later.
REQ-037 Parameter: ACCESS_LAT=1 -> first beat 2 cycles after strobe edge, done at cycle 34.
